// File: rtl/aes_keyram_pkg.sv
// Shared types and helpers for the multi-slot AES round-key store.
// Optional zeroize support is enabled with AES_KEYRAM_ZEROIZE_EN.
package aes_keyram_pkg;

  localparam logic [3:0] AES_NR_128 = 4'd10;
  localparam logic [3:0] AES_NR_192 = 4'd12;
  localparam logic [3:0] AES_NR_256 = 4'd14;

`ifdef AES_KEYRAM_ZEROIZE_EN
  typedef enum logic [1:0] {IDLE, LOAD, WIPE} wr_state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} wr_state_t;
`endif

  // A round count is usable only if it is a real AES Nr and fits the reserved slot depth.
  function automatic logic nr_legal(input logic [3:0] nr, input int max_rounds);
    return ((nr == AES_NR_128) || (nr == AES_NR_192) || (nr == AES_NR_256)) &&
           (int'(nr) <= max_rounds);
  endfunction

  function automatic logic slot_in_range(input int slot, input int num_keys);
    return slot < num_keys;
  endfunction

  // Each slot owns (max_rounds+1) round keys of two 64-bit halves; half 0 is key[127:64].
  function automatic int keyram_addr(input int slot, input int round, input int half,
                                     input int max_rounds);
    return slot * (max_rounds + 1) * 2 + round * 2 + half;
  endfunction

endpackage

// File: rtl/aes_keyram_dpram.sv
// 64-bit simple dual-port RAM: one write port, one synchronous read port.
module aes_keyram_dpram #(
  parameter int    DEPTH     = 60,
  parameter int    ADDR_W    = 6,
  parameter string RAM_STYLE = "block"
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [63:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [63:0]       rdata
);

  (* ram_style = RAM_STYLE *) logic [63:0] mem [DEPTH];

  // NOTE: the array and read register have no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking writes keep read-during-write returning the old word, as a real RAM does.
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/aes_keyram_multislot.sv
// Multi-slot AES round-key store: 64-bit beat loader, 128-bit round-key reader.
// Define AES_KEYRAM_ZEROIZE_EN to add the zeroize input and RAM wipe sweep.
module aes_keyram_multislot
  import aes_keyram_pkg::*;
#(
  parameter int    NUM_KEYS   = 2,
  parameter int    MAX_ROUNDS = 14,
  parameter string RAM_STYLE  = "block",
  localparam int   SLOT_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                kill,
`ifdef AES_KEYRAM_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                wr_en,
  input  logic [SLOT_W-1:0]   wr_slot,
  input  logic [3:0]          wr_nr,
  input  logic [63:0]         wr_data,
  output logic                wr_idle,
  output logic                wr_err,
  output logic [NUM_KEYS-1:0] slot_valid,
  input  logic                rd_req,
  input  logic [SLOT_W-1:0]   rd_slot,
  input  logic [3:0]          rd_round,
  output logic                rd_busy,
  output logic                rd_valid,
  output logic                rd_err,
  output logic [127:0]        rd_data
);

  localparam int DEPTH  = NUM_KEYS * (MAX_ROUNDS + 1) * 2;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(2 * (MAX_ROUNDS + 1));

  wr_state_t                 state_q, state_d;
  logic [SLOT_W-1:0]         ld_slot_q;
  logic [3:0]                ld_nr_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [NUM_KEYS-1:0]       slot_valid_q;
  logic [NUM_KEYS-1:0][3:0]  slot_nr_q;
  logic                      wr_err_q;
  logic                      load_start, load_beat, load_done, load_reject;

  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_waddr, ram_raddr;
  logic [63:0]               ram_wdata, ram_rdata;

  logic [1:0]                rd_phase_q;
  logic [SLOT_W-1:0]         rd_slot_q;
  logic [3:0]                rd_round_q;
  logic                      rd_bad_q;
  logic [63:0]               half0_q;
  logic                      rd_valid_q, rd_err_q;
  logic [127:0]              rd_data_q;
  logic                      rd_ok, rd_accept, rd_blocked;

`ifdef AES_KEYRAM_ZEROIZE_EN
  logic [ADDR_W-1:0]         wipe_addr_q;
`endif

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or posedge kill) begin
    if (kill) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    load_start  = 1'b0;
    load_beat   = 1'b0;
    load_done   = 1'b0;
    load_reject = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (nr_legal(wr_nr, MAX_ROUNDS) && slot_in_range(int'(wr_slot), NUM_KEYS)) begin
            load_start = 1'b1;
            ram_we     = 1'b1;
            ram_waddr  = ADDR_W'(keyram_addr(int'(wr_slot), 0, 0, MAX_ROUNDS));
            ram_wdata  = wr_data;
            state_d    = LOAD;
          end else begin
            load_reject = 1'b1;
          end
        end
      end
      LOAD: begin
        if (wr_en) begin
          load_beat = 1'b1;
          ram_we    = 1'b1;
          ram_waddr = ADDR_W'(keyram_addr(int'(ld_slot_q), int'(beat_q >> 1),
                                          int'(beat_q[0]), MAX_ROUNDS));
          ram_wdata = wr_data;
          if (beat_q == BEAT_W'(2 * (int'(ld_nr_q) + 1) - 1)) begin
            load_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
`ifdef AES_KEYRAM_ZEROIZE_EN
      WIPE: begin
        ram_we    = 1'b1;
        ram_waddr = wipe_addr_q;
        if (wipe_addr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef AES_KEYRAM_ZEROIZE_EN
    // Zeroize wins over everything, including a sweep already in progress.
    if (zeroize) begin
      state_d     = WIPE;
      ram_we      = 1'b0;
      load_start  = 1'b0;
      load_beat   = 1'b0;
      load_done   = 1'b0;
      load_reject = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      ld_slot_q    <= '0;
      ld_nr_q      <= '0;
      beat_q       <= '0;
      slot_valid_q <= '0;
      slot_nr_q    <= '0;
      wr_err_q     <= 1'b0;
`ifdef AES_KEYRAM_ZEROIZE_EN
      wipe_addr_q  <= '0;
`endif
    end else begin
      wr_err_q <= load_reject;
      if (load_start) begin
        ld_slot_q             <= wr_slot;
        ld_nr_q               <= wr_nr;
        beat_q                <= BEAT_W'(1);
        slot_valid_q[wr_slot] <= 1'b0;
        slot_nr_q[wr_slot]    <= wr_nr;
      end else if (load_beat) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
      if (load_done) slot_valid_q[ld_slot_q] <= 1'b1;
`ifdef AES_KEYRAM_ZEROIZE_EN
      if (zeroize) begin
        slot_valid_q <= '0;
        wipe_addr_q  <= '0;
      end else if (state_q == WIPE) begin
        wipe_addr_q <= wipe_addr_q + ADDR_W'(1);
      end
`endif
    end
  end

  // ---------------------------------------------------------------- read sequencer
`ifdef AES_KEYRAM_ZEROIZE_EN
  assign rd_blocked = (state_q == WIPE);
`else
  assign rd_blocked = 1'b0;
`endif

  // Validity is judged at acceptance; a later reload does not retroactively fail the read.
  assign rd_ok = slot_in_range(int'(rd_slot), NUM_KEYS) && slot_valid_q[rd_slot] &&
                 (rd_round <= slot_nr_q[rd_slot]);

  // Phase 3 is the last busy cycle, so a new request can overlap it for 1 key / 3 cycles.
  assign rd_accept = rd_req && !rd_blocked && ((rd_phase_q == 2'd0) || (rd_phase_q == 2'd3));
  assign ram_raddr = ADDR_W'(keyram_addr(int'(rd_slot_q), int'(rd_round_q),
                                         int'(rd_phase_q == 2'd2), MAX_ROUNDS));

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      rd_phase_q <= 2'd0;
      rd_slot_q  <= '0;
      rd_round_q <= '0;
      rd_bad_q   <= 1'b0;
      half0_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (rd_accept) begin
        rd_phase_q <= 2'd1;
        rd_slot_q  <= rd_slot;
        rd_round_q <= rd_round;
        rd_bad_q   <= !rd_ok;
      end else if (rd_phase_q != 2'd0) begin
        rd_phase_q <= rd_phase_q + 2'd1;
      end
      if (rd_phase_q == 2'd2) half0_q <= ram_rdata;
      rd_valid_q <= (rd_phase_q == 2'd3);
      rd_err_q   <= (rd_phase_q == 2'd3) && rd_bad_q;
      if (rd_phase_q == 2'd3) rd_data_q <= rd_bad_q ? '0 : {half0_q, ram_rdata};
    end
  end

  aes_keyram_dpram #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RAM_STYLE(RAM_STYLE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign wr_idle    = (state_q == IDLE);
  assign wr_err     = wr_err_q;
  assign slot_valid = slot_valid_q;
  assign rd_busy    = (rd_phase_q != 2'd0) || rd_blocked;
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_aes_keyram_multislot.sv
// Bench for aes_keyram_multislot: directed sequence with random key data against a slot/round-level model.
module tb_aes_keyram_multislot;

  localparam int NUM_KEYS = 2;
  localparam int SLOT_W   = 1;
  localparam int DEPTH    = NUM_KEYS * 15 * 2;

  logic                clk = 1'b0;
  logic                kill;
  logic                zeroize;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_slot;
  logic [3:0]          wr_nr;
  logic [63:0]         wr_data;
  logic                wr_idle, wr_err;
  logic [NUM_KEYS-1:0] slot_valid;
  logic                rd_req;
  logic [SLOT_W-1:0]   rd_slot;
  logic [3:0]          rd_round;
  logic                rd_busy, rd_valid, rd_err;
  logic [127:0]        rd_data;

  always #5 clk = ~clk;

  aes_keyram_multislot #(.NUM_KEYS(NUM_KEYS), .MAX_ROUNDS(14), .RAM_STYLE("block")) dut (
    .clk       (clk),
    .kill      (kill),
`ifdef AES_KEYRAM_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_nr     (wr_nr),
    .wr_data   (wr_data),
    .wr_idle   (wr_idle),
    .wr_err    (wr_err),
    .slot_valid(slot_valid),
    .rd_req    (rd_req),
    .rd_slot   (rd_slot),
    .rd_round  (rd_round),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .rd_data   (rd_data)
  );

  // Reference model: whole round keys per slot, plus the loader's progress.
  typedef struct {
    int           due;
    logic         err;
    logic [127:0] data;
  } rd_exp_t;

  logic [127:0]        m_key [NUM_KEYS][16];
  logic [NUM_KEYS-1:0] m_valid;
  int                  m_nr [NUM_KEYS];
  bit                  ld_active;
  int                  ld_slot, ld_nr, ld_beat;
  int                  wipe_left;
  logic                exp_err;
  rd_exp_t             rq[$];
  int                  cyc;
  logic [127:0]        last_data;
  string               stage;
  int                  checks = 0;
  int                  errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s:%s observed %0h expected %0h", stage, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ld_active = 0;
    m_valid   = '0;
    for (int s = 0; s < NUM_KEYS; s++) m_nr[s] = 0;
    wipe_left = 0;
    exp_err   = 1'b0;
    rq.delete();
  endtask

  // One clock: predict from the inputs about to be sampled, advance, then compare.
  task automatic tick();
    rd_exp_t r;
    int      s, rn, wipe_next;
    exp_err = 1'b0;
    if (rd_req && wipe_left == 0 && !zeroize) begin
      s      = int'(rd_slot);
      rn     = int'(rd_round);
      r.due  = cyc + 4;
      r.err  = (s >= NUM_KEYS) || !m_valid[s] || (rn > m_nr[s]);
      r.data = r.err ? 128'd0 : m_key[s][rn];
      rq.push_back(r);
    end
    if (wr_en && wipe_left == 0 && !zeroize) begin
      if (!ld_active) begin
        if ((wr_nr == 4'd10 || wr_nr == 4'd12 || wr_nr == 4'd14) && int'(wr_slot) < NUM_KEYS) begin
          ld_active        = 1;
          ld_slot          = int'(wr_slot);
          ld_nr            = int'(wr_nr);
          ld_beat          = 0;
          m_valid[ld_slot] = 1'b0;
          m_nr[ld_slot]    = ld_nr;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (ld_active) begin
        if (ld_beat % 2 == 0) m_key[ld_slot][ld_beat / 2][127:64] = wr_data;
        else                  m_key[ld_slot][ld_beat / 2][63:0]   = wr_data;
        if (ld_beat == 2 * (ld_nr + 1) - 1) begin
          ld_active        = 0;
          m_valid[ld_slot] = 1'b1;
        end
        ld_beat++;
      end
    end
    if (zeroize) begin
      ld_active = 0;
      m_valid   = '0;
      for (int a = 0; a < NUM_KEYS; a++)
        for (int b = 0; b < 16; b++) m_key[a][b] = '0;
      wipe_next = DEPTH;
    end else begin
      wipe_next = (wipe_left > 0) ? wipe_left - 1 : 0;
    end

    @(posedge clk);
    #1;
    cyc++;
    wipe_left = wipe_next;
    wr_en     = 1'b0;
    rd_req    = 1'b0;
    zeroize   = 1'b0;

    check("wr_idle", 128'(wr_idle), 128'(!ld_active && wipe_left == 0));
    check("wr_err", 128'(wr_err), 128'(exp_err));
    check("slot_valid", 128'(slot_valid), 128'(m_valid));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rd_valid", 128'(rd_valid), 128'd1);
      check("rd_err", 128'(rd_err), 128'(rq[0].err));
      check("rd_data", rd_data, rq[0].data);
      last_data = rd_data;
      void'(rq.pop_front());
    end else begin
      check("rd_valid_idle", 128'(rd_valid), 128'd0);
      check("rd_err_idle", 128'(rd_err), 128'd0);
    end
    check("rd_busy", 128'(rd_busy), 128'(rq.size() > 0 || wipe_left > 0));
  endtask

  task automatic load_key(input int slot, input int nr, input bit ramp);
    for (int b = 0; b < 2 * (nr + 1); b++) begin
      wr_en   = 1'b1;
      wr_slot = SLOT_W'(slot);
      wr_nr   = 4'(nr);
      wr_data = ramp ? 64'(b) : {$urandom, $urandom};
      tick();
    end
  endtask

  task automatic read_key(input int slot, input int round);
    rd_req   = 1'b1;
    rd_slot  = SLOT_W'(slot);
    rd_round = 4'(round);
    tick();
    tick();
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && rq.size() > 0; i++) tick();
  endtask

  task automatic do_kill();
    #2;
    kill = 1'b1;
    #1;
    model_reset();
    check("kill_wr_idle", 128'(wr_idle), 128'd1);
    check("kill_wr_err", 128'(wr_err), 128'd0);
    check("kill_slot_valid", 128'(slot_valid), 128'd0);
    check("kill_rd_busy", 128'(rd_busy), 128'd0);
    check("kill_rd_valid", 128'(rd_valid), 128'd0);
    check("kill_rd_err", 128'(rd_err), 128'd0);
    check("kill_rd_data", rd_data, 128'd0);
    @(negedge clk);
    kill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int beat, rn, c;
    kill     = 1'b1;
    zeroize  = 1'b0;
    wr_en    = 1'b0;
    wr_slot  = '0;
    wr_nr    = '0;
    wr_data  = '0;
    rd_req   = 1'b0;
    rd_slot  = '0;
    rd_round = '0;
    cyc      = 0;
    last_data = '0;
    model_reset();
    for (int a = 0; a < NUM_KEYS; a++)
      for (int b = 0; b < 16; b++) m_key[a][b] = '0;

    stage = "reset";
    repeat (2) @(posedge clk);
    #1;
    check("wr_idle", 128'(wr_idle), 128'd1);
    check("wr_err", 128'(wr_err), 128'd0);
    check("slot_valid", 128'(slot_valid), 128'd0);
    check("rd_busy", 128'(rd_busy), 128'd0);
    check("rd_valid", 128'(rd_valid), 128'd0);
    check("rd_err", 128'(rd_err), 128'd0);
    check("rd_data", rd_data, 128'd0);
    @(negedge clk);
    kill = 1'b0;

    // Slot 0, AES-128, beat i carries value i.
    stage = "t1";
    load_key(0, 10, 1'b1);
    read_key(0, 3);
    drain();
    check("round3_key", last_data, {64'd6, 64'd7});

    // Slot 1, AES-256 with stalls, while slot 0 is read back-to-back.
    stage = "t2";
    beat = 0;
    rn   = 0;
    c    = 0;
    while ((beat < 30 || rn < 11) && c < 200) begin
      if (beat < 30 && !(c inside {2, 5, 9, 13, 17})) begin
        wr_en   = 1'b1;
        wr_slot = SLOT_W'(1);
        wr_nr   = 4'd14;
        wr_data = {$urandom, $urandom};
        beat++;
      end
      if (rn < 11 && c % 3 == 0) begin
        rd_req   = 1'b1;
        rd_slot  = SLOT_W'(0);
        rd_round = 4'(rn);
        rn++;
      end
      tick();
      c++;
    end
    drain();
    check("both_valid", 128'(slot_valid), 128'(2'b11));
    read_key(1, 14);
    read_key(1, 15);
    drain();

    // Illegal Nr is rejected; out-of-range round reads error.
    stage = "t3";
    wr_en   = 1'b1;
    wr_slot = SLOT_W'(0);
    wr_nr   = 4'd11;
    wr_data = 64'hdead_beef_0000_0001;
    tick();
    tick();
    read_key(0, 11);
    drain();
    check("round11_zero", last_data, 128'd0);
    read_key(0, 10);
    drain();

    // Reload slot 0 then kill mid-load with a read of slot 1 in flight.
    stage = "t4";
    for (int b = 0; b < 6; b++) begin
      wr_en   = 1'b1;
      wr_slot = SLOT_W'(0);
      wr_nr   = 4'd12;
      wr_data = {$urandom, $urandom};
      if (b == 5) begin
        rd_req   = 1'b1;
        rd_slot  = SLOT_W'(1);
        rd_round = 4'd2;
      end
      tick();
    end
    do_kill();
    repeat (4) tick();
    read_key(0, 0);
    drain();

    // Read of a slot while it is loading errors; afterwards the new key is returned.
    stage = "t5";
    for (int b = 0; b < 26; b++) begin
      wr_en   = 1'b1;
      wr_slot = SLOT_W'(1);
      wr_nr   = 4'd12;
      wr_data = {$urandom, $urandom};
      if (b == 1) begin
        rd_req   = 1'b1;
        rd_slot  = SLOT_W'(1);
        rd_round = 4'd0;
      end
      tick();
    end
    drain();
    read_key(1, 0);
    read_key(1, 12);
    read_key(1, 13);
    drain();

    // Random reads across both slots, including rounds beyond Nr.
    stage = "rand";
    load_key(0, 14, 1'b0);
    for (int i = 0; i < 24; i++) read_key($urandom_range(0, NUM_KEYS - 1), $urandom_range(0, 15));
    drain();

`ifdef AES_KEYRAM_ZEROIZE_EN
    stage = "t6";
    load_key(1, 10, 1'b0);
    zeroize = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) begin
        rd_req   = 1'b1;
        rd_slot  = SLOT_W'(0);
        rd_round = 4'd0;
      end
      tick();
    end
    check("wiped_invalid", 128'(slot_valid), 128'd0);
    read_key(0, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
